// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared layer codes, sequencer state and error-code types for
//               the CNN layer-control handshake.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  // Layer codes carried on ctrl / return_ctrl
  localparam logic [7:0] CTRL_IDLE  = 8'd0;
  localparam logic [7:0] CTRL_LOAD  = 8'd1;
  localparam logic [7:0] CTRL_CONV1 = 8'd2;
  localparam logic [7:0] CTRL_POOL1 = 8'd3;
  localparam logic [7:0] CTRL_CONV2 = 8'd4;
  localparam logic [7:0] CTRL_POOL2 = 8'd5;
  localparam logic [7:0] CTRL_FC    = 8'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_PROTOCOL = 2'b10,
    ERR_ABORT    = 2'b11
  } err_code_t;

endpackage
`default_nettype wire

// File: rtl/cnn_stage_timer.sv
`default_nettype none
// ============================================================================
// Module      : cnn_stage_timer
// Description : Per-stage wait counter. Cleared on stage entry, counts while
//               enabled and stops once it has reached the limit.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_stage_timer #(
  parameter  int unsigned TIMEOUT_CYCLES = 2**20,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             w_expired;

  // Limit reached: the counter holds here so it can never wrap back to zero
  always_comb begin
    w_expired = (cnt_q >= limit_i);
  end

  // Stage wait counter with clear priority over counting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !w_expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = w_expired;

endmodule
`default_nettype wire

// File: rtl/cnn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cnn_sequencer
// Description : Initiator side of the layer-control handshake. Steps ctrl
//               through clear, image load and the five compute layers,
//               advancing only when return_ctrl echoes the current layer.
// Revision    : 1.0 - initial release
// ============================================================================
module cnn_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        img_loaded_i,
  input  logic        abort_i,
  input  logic [7:0]  return_ctrl_i,
  output logic [7:0]  ctrl_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        done_pulse_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [2:0]  err_stage_o,
  output logic [31:0] total_cycles_o
);

  localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  CLR_LAST = 8'(CLEAR_CYCLES - 1);

  seq_state_t  state_q;
  logic [7:0]  ctrl_q;
  logic [2:0]  stage_q;
  logic        settle_q;
  logic [7:0]  clr_cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        done_pulse_q;
  logic        error_q;
  err_code_t   err_code_q;
  logic [2:0]  err_stage_q;
  logic [31:0] total_q;

  logic        w_busy_st;
  logic        w_eval;
  logic        w_rc_match;
  logic        w_rc_wait;
  logic        w_go_clear;
  logic        w_go_err;
  err_code_t   w_err;
  logic        w_tmr_clear;
  logic        w_tmr_en;
  logic        w_expired;

  // Decode handshake outcome and error priority: abort > protocol > completion > timeout
  always_comb begin
    w_busy_st  = (state_q == ST_CLEAR) || (state_q == ST_LOAD) || (state_q == ST_RUN);
    w_eval     = (state_q == ST_RUN) && !settle_q;
    w_rc_match = (return_ctrl_i == {5'd0, stage_q});
    w_rc_wait  = (return_ctrl_i == {5'd0, stage_q - 3'd1});
    w_go_clear = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                             ((state_q == ST_ERROR) && !abort_i));
    w_go_err   = 1'b0;
    w_err      = ERR_NONE;
    if (w_busy_st && abort_i) begin
      w_go_err = 1'b1;
      w_err    = ERR_ABORT;
    end else if (w_eval && !w_rc_match && !w_rc_wait) begin
      w_go_err = 1'b1;
      w_err    = ERR_PROTOCOL;
    end else if (w_eval && !w_rc_match && w_expired) begin
      w_go_err = 1'b1;
      w_err    = ERR_TIMEOUT;
    end
    // Timer restarts whenever a stage is (re)entered; it only counts in-progress echoes
    w_tmr_clear = (state_q != ST_RUN) || (w_eval && w_rc_match);
    w_tmr_en    = w_eval && w_rc_wait;
  end

  cnn_stage_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (w_tmr_clear),
    .enable_i  (w_tmr_en),
    .limit_i   (TMR_W'(TIMEOUT_CYCLES)),
    .expired_o (w_expired)
  );

  // Sequencer FSM with registered ctrl and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= CTRL_IDLE;
      stage_q      <= 3'd0;
      settle_q     <= 1'b0;
      clr_cnt_q    <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_stage_q  <= 3'd0;
      total_q      <= 32'd0;
    end else begin
      done_pulse_q <= 1'b0;
      if (w_busy_st && (total_q != 32'hFFFF_FFFF)) begin
        total_q <= total_q + 32'd1;
      end
      if (w_go_clear) begin
        state_q     <= ST_CLEAR;
        ctrl_q      <= CTRL_IDLE;
        stage_q     <= 3'd0;
        settle_q    <= 1'b0;
        clr_cnt_q   <= 8'd0;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        error_q     <= 1'b0;
        err_code_q  <= ERR_NONE;
        err_stage_q <= 3'd0;
        total_q     <= 32'd0;
      end else if (w_go_err) begin
        state_q     <= ST_ERROR;
        ctrl_q      <= CTRL_IDLE;
        busy_q      <= 1'b0;
        error_q     <= 1'b1;
        err_code_q  <= w_err;
        err_stage_q <= ctrl_q[2:0];
      end else begin
        case (state_q)
          ST_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
              state_q <= ST_LOAD;
              ctrl_q  <= CTRL_LOAD;
            end else begin
              clr_cnt_q <= clr_cnt_q + 8'd1;
            end
          end
          ST_LOAD: begin
            if (img_loaded_i) begin
              state_q  <= ST_RUN;
              stage_q  <= CTRL_CONV1[2:0];
              ctrl_q   <= CTRL_CONV1;
              settle_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (settle_q) begin
              settle_q <= 1'b0;
            end else if (w_rc_match) begin
              if (stage_q == CTRL_FC[2:0]) begin
                state_q      <= ST_DONE;
                ctrl_q       <= CTRL_IDLE;
                busy_q       <= 1'b0;
                done_q       <= 1'b1;
                done_pulse_q <= 1'b1;
              end else begin
                stage_q  <= stage_q + 3'd1;
                ctrl_q   <= {5'd0, stage_q + 3'd1};
                settle_q <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ctrl_o         = ctrl_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign done_pulse_o   = done_pulse_q;
  assign error_o        = error_q;
  assign err_code_o     = err_code_q;
  assign err_stage_o    = err_stage_q;
  assign total_cycles_o = total_q;

endmodule
`default_nettype wire

// File: tb/tb_cnn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnn_sequencer
// Description : Scoreboard bench for cnn_sequencer. Stimulus tasks derive the
//               expected output changes (value and cycle) from the handshake
//               rules and queue them; a monitor pops one entry per observed
//               output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_sequencer;

  localparam int CC = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic        img_loaded_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [7:0]  return_ctrl_i = 8'd0;
  logic [7:0]  ctrl_o;
  logic        busy_o;
  logic        done_o;
  logic        done_pulse_o;
  logic        error_o;
  logic [1:0]  err_code_o;
  logic [2:0]  err_stage_o;
  logic [31:0] total_cycles_o;

  cnn_sequencer #(
    .CLEAR_CYCLES   (CC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start_i),
    .img_loaded_i   (img_loaded_i),
    .abort_i        (abort_i),
    .return_ctrl_i  (return_ctrl_i),
    .ctrl_o         (ctrl_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .done_pulse_o   (done_pulse_o),
    .error_o        (error_o),
    .err_code_o     (err_code_o),
    .err_stage_o    (err_stage_o),
    .total_cycles_o (total_cycles_o)
  );

  always #5 clk = ~clk;

  // number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          at;
    logic [7:0]  ctrl;
    logic        busy, done, pulse, err;
    logic [1:0]  code;
    logic [2:0]  stg;
    logic [31:0] tc;
  } exp_t;

  exp_t q[$];

  // expected visible status, updated by the stimulus tasks
  logic [7:0] m_ctrl = 8'd0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_pulse = 1'b0, m_err = 1'b0;
  logic [1:0] m_code = 2'd0;
  logic [2:0] m_stg = 3'd0;

  function automatic void mset(int c, int b, int dn, int p, int er, int cd, int st);
    m_ctrl = 8'(c); m_busy = (b != 0); m_done = (dn != 0); m_pulse = (p != 0);
    m_err = (er != 0); m_code = 2'(cd); m_stg = 3'(st);
  endfunction

  function automatic void push(int at, int tc);
    exp_t e;
    e.at = at; e.ctrl = m_ctrl; e.busy = m_busy; e.done = m_done; e.pulse = m_pulse;
    e.err = m_err; e.code = m_code; e.stg = m_stg; e.tc = 32'(tc);
    q.push_back(e);
  endfunction

  // values driven here are sampled at rising edge cyc+1
  task automatic drive(input int st, input int il, input int ab, input int rc);
    @(negedge clk);
    start_i = (st != 0); img_loaded_i = (il != 0); abort_i = (ab != 0);
    return_ctrl_i = 8'(rc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  // One job. fk: 0 none, 1 timeout in stage fs, 2 protocol in fs after fd waits,
  // 3 bad code in settle cycle of fs only, 4 abort in LOAD, 5 abort in fs after
  // fd waits, 6 reset in fs after fd waits, 7 start pulse during stage fs.
  task automatic job(input int ld, input int d[5], input int fk, input int fs, input int fd);
    int s, t, e, w, bad;
    drive(1, 0, 0, 0);
    s = cyc + 1;
    mset(0, 1, 0, 0, 0, 0, 0); push(s, 0);
    mset(1, 1, 0, 0, 0, 0, 0); push(s + CC, CC);
    drive(0, 1, 0, 0);  // stray image-loaded pulse while still clearing
    for (int i = 0; i < CC - 1 + ld; i++) drive(0, 0, 0, 0);
    if (fk == 4) begin
      drive(0, 0, 1, 0);
      e = cyc + 1;
      mset(0, 0, 0, 0, 1, 3, 1); push(e, e - s);
      drive(1, 0, 1, 0);  // start with abort still high must be ignored
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
      return;
    end
    drive(0, 1, 0, 0);
    t = cyc + 1;
    mset(2, 1, 0, 0, 0, 0, 0); push(t, t - s);
    for (int k = 2; k <= 6; k++) begin
      bad = (k <= 4) ? 5 : 1;
      drive(0, 0, 0, (fk == 3 && fs == k) ? bad : k - 1);
      if (fk == 1 && fs == k) begin
        e = t + 2 + TO;
        mset(0, 0, 0, 0, 1, 1, k); push(e, e - s);
        for (int i = 0; i <= TO; i++) drive(0, 0, 0, k - 1);
        drive(0, 0, 0, 0);
        return;
      end
      w = ((fk == 2 || fk == 5 || fk == 6) && fs == k) ? fd : d[k-2];
      for (int i = 0; i < w; i++) drive((fk == 7 && fs == k && i == 0) ? 1 : 0, 0, 0, k - 1);
      e = t + 2 + w;
      if (fk == 2 && fs == k) begin
        mset(0, 0, 0, 0, 1, 2, k); push(e, e - s);
        drive(0, 0, 0, bad);
        drive(0, 0, 0, 0);
        return;
      end
      if (fk == 5 && fs == k) begin
        mset(0, 0, 0, 0, 1, 3, k); push(e, e - s);
        drive(0, 0, 1, k - 1);
        drive(1, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        return;
      end
      if (fk == 6 && fs == k) begin
        @(negedge clk);
        mset(0, 0, 0, 0, 0, 0, 0); push(cyc + 1, 0);
        reset_n = 1'b0; start_i = 1'b0; img_loaded_i = 1'b0; abort_i = 1'b0;
        return_ctrl_i = 8'd0;
        #1;
        checks++;
        if ({ctrl_o, busy_o, done_o, done_pulse_o, error_o, err_code_o, err_stage_o,
             total_cycles_o} !== 49'd0) begin
          errors++;
          $display("FAIL reset_async got ctrl=%0d busy=%0b err=%0b total=%0d required all zero",
                   ctrl_o, busy_o, error_o, total_cycles_o);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (k < 6) begin
        mset(k + 1, 1, 0, 0, 0, 0, 0); push(e, e - s);
        drive(0, 0, 0, k);
        t = e;
      end else begin
        mset(0, 0, 1, 1, 0, 0, 0); push(e, e - s);
        mset(0, 0, 1, 0, 0, 0, 0); push(e + 1, e - s);
        drive(0, 0, 0, 6);
        drive(0, 0, 0, 0);
      end
    end
  endtask

  // Monitor: every change of the visible status consumes one expected entry
  logic [16:0] cur, prev, expv;
  exp_t        ex;
  initial begin
    prev = 17'd0;
    forever begin
      @(posedge clk);
      #1;
      cur = {ctrl_o, busy_o, done_o, done_pulse_o, error_o, err_code_o, err_stage_o};
      if (cur !== prev) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
        end else begin
          ex = q.pop_front();
          expv = {ex.ctrl, ex.busy, ex.done, ex.pulse, ex.err, ex.code, ex.stg};
          checks++;
          if (cur !== expv) begin
            errors++;
            $display("FAIL outputs cyc=%0d got ctrl=%0d busy=%0b done=%0b pulse=%0b err=%0b code=%0d stage=%0d required ctrl=%0d busy=%0b done=%0b pulse=%0b err=%0b code=%0d stage=%0d",
                     cyc, ctrl_o, busy_o, done_o, done_pulse_o, error_o, err_code_o, err_stage_o,
                     ex.ctrl, ex.busy, ex.done, ex.pulse, ex.err, ex.code, ex.stg);
          end
          checks++;
          if (cyc != ex.at) begin
            errors++;
            $display("FAIL event_time got cyc=%0d required cyc=%0d", cyc, ex.at);
          end
          checks++;
          if (total_cycles_o !== ex.tc) begin
            errors++;
            $display("FAIL total_cycles cyc=%0d got=%0d required=%0d", cyc, total_cycles_o, ex.tc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  int dd[5];

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    if ({ctrl_o, busy_o, done_o, done_pulse_o, error_o, err_code_o, err_stage_o,
         total_cycles_o} !== 49'd0) begin
      errors++;
      $display("FAIL reset_state got ctrl=%0d busy=%0b done=%0b err=%0b total=%0d required all zero",
               ctrl_o, busy_o, done_o, error_o, total_cycles_o);
    end
    reset_n = 1'b1;
    drive(0, 0, 1, 0);  // abort in IDLE has no effect
    idle(2);

    dd = '{5, 5, 5, 5, 5};
    job(4, dd, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 0);  // abort in DONE has no effect
    idle(1);

    dd = '{0, 0, 0, 0, 0};
    job(0, dd, 0, 0, 0);

    dd = '{TO, 0, 1, 0, TO};
    job(1, dd, 0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 5; i++) dd[i] = int'($urandom_range(12, 1));
      job(int'($urandom_range(5, 0)), dd, 7, int'($urandom_range(6, 2)), 0);
      idle(int'($urandom_range(3, 0)));
    end

    dd = '{3, 2, 1, 2, 3};
    job(2, dd, 1, 4, 0);
    idle(2);
    job(1, dd, 3, 2, 0);
    job(0, dd, 2, 2, int'($urandom_range(4, 0)));
    job(2, dd, 4, 0, 0);
    job(0, dd, 5, int'($urandom_range(6, 2)), int'($urandom_range(3, 0)));
    job(1, dd, 6, 5, 2);
    idle(4);
    job(2, dd, 0, 0, 0);
    idle(5);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cnn_sequencer.md
# cnn_sequencer

Initiator side of the 8-bit layer-control handshake that drives the CNN layer controller. It steps `ctrl` through clear → image load → conv1 → pool1 → conv2 → pool2 → FC, and advances each layer only when `return_ctrl` echoes the layer code. It sits between the host-facing register block and the layer controller, and provides start/abort, completion, error and cycle-count status to software.

## Interface
- `CLEAR_CYCLES`, default 2: cycles `ctrl` is held at 0 before image load (range 1–255).
- `TIMEOUT_CYCLES`, default 2^20: maximum cycles per layer stage before a timeout error.
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; honoured only in IDLE, DONE or ERROR.
- `img_loaded` in 1: one-cycle pulse from the host; the image memory is fully written.
- `abort` in 1: level; forces the ERROR state from any busy state.
- `return_ctrl` in 8: layer-controller status code.
- `ctrl` out 8: registered layer code to the controller.
- `busy` out 1: high in CLEAR, LOAD or RUN.
- `done` out 1: sticky; high in the DONE state.
- `done_pulse` out 1: one-cycle pulse on entry to DONE.
- `error` out 1: sticky; high in the ERROR state.
- `err_code` out 2: 01 = timeout, 10 = protocol, 11 = abort.
- `err_stage` out 3: value of `ctrl[2:0]` at the time of the error.
- `total_cycles` out 32: cycles from leaving IDLE to entering DONE.

## Operation
- Layer codes: 0 IDLE, 1 LOAD, 2 CONV1, 3 POOL1, 4 CONV2, 5 POOL2, 6 FC. The controller returns `k` when layer `k` is finished and `k-1` while it is in progress.
- States are IDLE, CLEAR, LOAD, RUN, DONE, ERROR. A 3-bit `stage` register is used inside RUN.
- **IDLE**
  - `ctrl`=0.
  - On `start`: go to CLEAR, zero `total_cycles`, clear `err_code` and `err_stage`.
- **CLEAR**
  - `ctrl`=0 for exactly `CLEAR_CYCLES` cycles, then go to LOAD.
- **LOAD**
  - `ctrl`=1.
  - Wait for `img_loaded`, then go to RUN with `stage`=2.
  - No timeout applies in LOAD.
  - An `img_loaded` pulse seen outside LOAD is ignored.
- **RUN**
  - `ctrl`=`stage`. A stage timer clears on entry to each stage.
  - The first cycle of each stage is a settle cycle: `return_ctrl` is not evaluated.
  - After the settle cycle, with `return_ctrl` sampled at each rising edge:
    - `return_ctrl`==`stage`: if `stage`<6, increment `stage`; if `stage`==6, go to DONE.
    - `return_ctrl`==`stage`-1: keep waiting and increment the timer.
    - Any other value: go to ERROR with `err_code`=10.
  - Timer reaching `TIMEOUT_CYCLES`: go to ERROR with `err_code`=01.
  - Priority: abort > protocol > completion > timeout.
- **DONE**
  - `ctrl`=0, `done`=1. Results stay valid in downstream memories.
  - `start` begins a new run (enters CLEAR) and clears `done`.
- **ERROR**
  - `ctrl`=0, `error`=1.
  - `start` clears `error` and enters CLEAR.
  - `abort` held high prevents leaving ERROR. `start` is ignored while `abort`=1.
- **abort** in CLEAR, LOAD or RUN: go to ERROR with `err_code`=11. `abort` in IDLE or DONE has no effect.
- **`total_cycles`**
  - Increments every cycle while `busy`.
  - Saturates at 0xFFFFFFFF.
  - Holds its value in DONE and ERROR.

## Timing
- Reset values: state=IDLE, `ctrl`=0, `stage`=0, `busy`=0, `done`=0, `done_pulse`=0, `error`=0, `err_code`=0, `err_stage`=0, `total_cycles`=0, timer=0.
- All outputs are registered. Edge N refers to the Nth rising edge of `clk`.
- `start` sampled at edge N: `ctrl`=0 and `busy`=1 from edge N+1.
- CLEAR: `ctrl`=1 appears `CLEAR_CYCLES` edges after CLEAR is entered.
- `img_loaded` sampled at edge N: `ctrl`=2 from edge N+1.
- Minimum stage length is 2 cycles: 1 settle cycle plus 1 match cycle.
- Match sampled at edge N: `ctrl`=`stage`+1 from edge N+1. For stage 6, `ctrl`=0 with `done`=1 and `done_pulse`=1 from edge N+1.
- Error and abort: status and `ctrl`=0 take effect 1 cycle after detection.
- `reset_n` asserted mid-operation: all outputs return to reset values immediately (asynchronously). Leaving reset requires a new `start`.

## Structure
- Shared package `cnn_pkg`:
  - layer code constants `CTRL_IDLE` … `CTRL_FC`;
  - `seq_state_t` enum;
  - `err_code_t` enum.
  - `cnn_ctrl` and the host register block import the same package.
- One sub-module, `cnn_stage_timer`:
  - clear, enable and limit inputs;
  - `expired` output;
  - counter width `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- Normal run, `CLEAR_CYCLES`=2. Stimulus: `start`; `img_loaded` at cycle 10; controller model finishes each layer after 5 cycles. Required: `ctrl` sequence 0,0,1…,2,3,4,5,6,0; `done_pulse` once; `total_cycles` equals the measured count.
- Instant completion. Stimulus: model returns `k` immediately for every layer. Required: each of stages 2–6 lasts exactly 2 cycles.
- Timeout, `TIMEOUT_CYCLES`=16. Stimulus: model returns 3 forever during stage 4. Required: `error`=1, `err_code`=01, `err_stage`=4, `ctrl`=0.
- Protocol violation. Stimulus: `return_ctrl` forced to 5 during stage 2, after the settle cycle. Required: `err_code`=10, `err_stage`=2. The same stimulus applied in the settle cycle only is ignored.
- Abort and reset. Stimulus: `abort` in LOAD. Required: `err_code`=11, `err_stage`=1; `start` while `abort`=1 is ignored. Stimulus: `reset_n` low during stage 5. Required: all outputs at reset values, then a normal rerun completes.
- Re-start. Stimulus: `start` in DONE. Required: `done` clears next cycle and the sequence begins again; `start` in RUN is ignored.
